// File: rtl/apb_rr_arbiter.sv
// Two-requester round-robin arbiter sequencing one APB master port.
// Owner's request is latched at grant; hung ACCESS phases abort after TIMEOUT cycles.
module apb_rr_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            state_reg, state_next;
    logic              last_reg, last_next;
    logic              owner_reg, owner_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [1:0]        gnt_reg, gnt_next;
    logic [1:0]        done_reg, done_next;
    logic [1:0]        err_reg, err_next;
    logic [DATA_W-1:0] rdata_reg [2];
    logic [DATA_W-1:0] rdata_next [2];
    logic              psel_reg, psel_next;
    logic              penable_reg, penable_next;
    logic              pwrite_reg, pwrite_next;
    logic [ADDR_W-1:0] paddr_reg, paddr_next;
    logic [DATA_W-1:0] pwdata_reg, pwdata_next;

    logic [1:0]        req;
    logic [1:0]        wr;
    logic [ADDR_W-1:0] addr_a [2];
    logic [DATA_W-1:0] wdata_a [2];
    logic              grant_valid;
    logic              grant_sel;

    assign req        = {req1, req0};
    assign wr         = {wr1, wr0};
    assign addr_a[0]  = addr0;
    assign addr_a[1]  = addr1;
    assign wdata_a[0] = wdata0;
    assign wdata_a[1] = wdata1;

    // Requester 0 wins unless requester 1 is alone or it is requester 1's turn.
    assign grant_valid = |req;
    assign grant_sel   = req[1] && (!req[0] || !last_reg);

    always_comb begin
        state_next   = state_reg;
        last_next    = last_reg;
        owner_next   = owner_reg;
        cnt_next     = cnt_reg;
        gnt_next     = gnt_reg;
        done_next    = 2'b00;
        err_next     = err_reg;
        rdata_next   = rdata_reg;
        psel_next    = psel_reg;
        penable_next = penable_reg;
        pwrite_next  = pwrite_reg;
        paddr_next   = paddr_reg;
        pwdata_next  = pwdata_reg;
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    owner_next            = grant_sel;
                    last_next             = grant_sel;
                    pwrite_next           = wr[grant_sel];
                    paddr_next            = addr_a[grant_sel];
                    pwdata_next           = wdata_a[grant_sel];
                    gnt_next              = 2'b00;
                    gnt_next[grant_sel]   = 1'b1;
                    psel_next             = 1'b1;
                    penable_next          = 1'b0;
                    state_next            = SETUP;
                end
            end
            SETUP: begin
                penable_next = 1'b1;
                cnt_next     = '0;
                state_next   = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    psel_next            = 1'b0;
                    penable_next         = 1'b0;
                    gnt_next             = 2'b00;
                    done_next[owner_reg] = 1'b1;
                    err_next[owner_reg]  = PSLVERR;
                    if (!pwrite_reg) begin
                        rdata_next[owner_reg] = PRDATA;
                    end
                    state_next = IDLE;
                end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
                    psel_next             = 1'b0;
                    penable_next          = 1'b0;
                    gnt_next              = 2'b00;
                    done_next[owner_reg]  = 1'b1;
                    err_next[owner_reg]   = 1'b1;
                    rdata_next[owner_reg] = '0;
                    state_next            = IDLE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_reg    <= IDLE;
            last_reg     <= 1'b1;
            owner_reg    <= 1'b0;
            cnt_reg      <= '0;
            gnt_reg      <= 2'b00;
            done_reg     <= 2'b00;
            err_reg      <= 2'b00;
            rdata_reg[0] <= '0;
            rdata_reg[1] <= '0;
            psel_reg     <= 1'b0;
            penable_reg  <= 1'b0;
            pwrite_reg   <= 1'b0;
            paddr_reg    <= '0;
            pwdata_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            last_reg     <= last_next;
            owner_reg    <= owner_next;
            cnt_reg      <= cnt_next;
            gnt_reg      <= gnt_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
            rdata_reg[0] <= rdata_next[0];
            rdata_reg[1] <= rdata_next[1];
            psel_reg     <= psel_next;
            penable_reg  <= penable_next;
            pwrite_reg   <= pwrite_next;
            paddr_reg    <= paddr_next;
            pwdata_reg   <= pwdata_next;
        end
    end

    assign gnt0    = gnt_reg[0];
    assign gnt1    = gnt_reg[1];
    assign done0   = done_reg[0];
    assign done1   = done_reg[1];
    assign err0    = err_reg[0];
    assign err1    = err_reg[1];
    assign rdata0  = rdata_reg[0];
    assign rdata1  = rdata_reg[1];
    assign PSEL    = psel_reg;
    assign PENABLE = penable_reg;
    assign PWRITE  = pwrite_reg;
    assign PADDR   = paddr_reg;
    assign PWDATA  = pwdata_reg;
endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter: write, wait-state read, alternation,
// timeout abort, slave error and asynchronous reset during ACCESS.
module tb_apb_rr_arbiter;
    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       req0, req1, wr0, wr1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       gnt0, gnt1, done0, done1, err0, err1;
    logic [7:0] rdata0, rdata1;
    logic       PSEL, PENABLE, PWRITE;
    logic [7:0] PADDR, PWDATA, PRDATA;
    logic       PREADY, PSLVERR;

    int total = 0;
    int bad   = 0;

    apb_rr_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample 1 time unit later, and check mutual exclusion.
    task automatic tick();
        @(posedge PCLK);
        #1;
        chk("exclusive", {30'd0, gnt0 & gnt1, done0 & done1}, 32'd0);
    endtask

    initial begin
        PRESET = 1'b1;
        req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        PRDATA = 0; PREADY = 0; PSLVERR = 0;
        #3;
        chk("reset_outs", {gnt0, gnt1, done0, done1, err0, err1, PSEL, PENABLE, PWRITE}, 32'd0);
        chk("reset_bus", {rdata0, rdata1, PADDR, PWDATA}, 32'd0);
        tick();
        PRESET = 1'b0;
        tick();
        chk("idle_psel", PSEL, 0);

        // Single write by requester 0
        req0 = 1; wr0 = 1; addr0 = 8'h10; wdata0 = 8'hA5; PREADY = 1;
        tick();
        chk("w_grant", {PSEL, PENABLE, gnt0, gnt1}, 32'b1010);
        chk("w_addr", {PWRITE, PADDR, PWDATA}, {15'd0, 1'b1, 8'h10, 8'hA5});
        addr0 = 8'hFF; wdata0 = 8'h00; wr0 = 0;
        tick();
        chk("w_access", {PSEL, PENABLE, done0}, 32'b110);
        chk("w_stable", {PWRITE, PADDR, PWDATA}, {15'd0, 1'b1, 8'h10, 8'hA5});
        tick();
        chk("w_done", {done0, gnt0, PSEL, PENABLE, err0}, 32'b10000);
        req0 = 0;
        tick();
        chk("w_pulse", {done0, PSEL}, 32'd0);

        // Read with 4 wait states by requester 1
        req1 = 1; wr1 = 0; addr1 = 8'h22; PREADY = 0;
        tick();
        chk("r_grant", {gnt1, PSEL, PENABLE, PWRITE}, 32'b1100);
        chk("r_addr", PADDR, 8'h22);
        tick();
        chk("r_access", PENABLE, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("r_wait", {PENABLE, done1}, 32'b10);
        end
        PREADY = 1; PRDATA = 8'h3C;
        tick();
        chk("r_done", {done1, err1, PENABLE, PSEL}, 32'b1000);
        chk("r_data", rdata1, 8'h3C);
        req1 = 0;
        tick();
        chk("r_pulse", done1, 0);

        // Both requesting: reads, order must alternate 0,1,0,1
        req0 = 1; req1 = 1; wr0 = 0; wr1 = 0; addr0 = 8'h01; addr1 = 8'h02; PRDATA = 8'h5A;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("rr_gnt", {gnt0, gnt1}, (t % 2 == 0) ? 32'b10 : 32'b01);
            tick();
            tick();
            chk("rr_done", {done0, done1}, (t % 2 == 0) ? 32'b10 : 32'b01);
            chk("rr_idle", {PSEL, gnt0, gnt1}, 32'd0);
            if (t == 3) begin
                req0 = 0; req1 = 0;
            end
        end
        chk("rr_rdata", {rdata0, rdata1}, 32'h5A5A);

        // Timeout on req0 read while req1 write is pending
        req0 = 1; req1 = 1; wr0 = 0; addr0 = 8'h33; wr1 = 1; addr1 = 8'h44; wdata1 = 8'h99;
        PREADY = 0; PRDATA = 8'h77;
        tick();
        chk("to_grant", {gnt0, gnt1}, 32'b10);
        tick();
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("to_wait", {PENABLE, done0, gnt1}, 32'b100);
        end
        tick();
        chk("to_abort", {done0, err0, PSEL, PENABLE, gnt0}, 32'b11000);
        chk("to_rdata", rdata0, 8'h00);
        req0 = 0; PREADY = 1; PSLVERR = 1;

        // Slave error on req1 write, then a clean req1 transfer clears it
        tick();
        chk("se_grant", {gnt1, gnt0, PWRITE}, 32'b101);
        chk("se_bus", {PADDR, PWDATA}, 32'h4499);
        tick();
        tick();
        chk("se_done", {done1, err1}, 32'b11);
        chk("se_rhold", rdata1, 8'h5A);
        PSLVERR = 0; wdata1 = 8'h11;
        tick();
        chk("se_persist", {gnt1, err1}, 32'b11);
        tick();
        tick();
        chk("se_clear", {done1, err1}, 32'b10);
        req1 = 0;
        tick();

        // Reset asserted asynchronously mid-ACCESS after req0 was served
        req0 = 1; wr0 = 1; addr0 = 8'h55; PREADY = 0;
        tick();
        chk("rs_grant", gnt0, 1);
        tick();
        tick();
        req1 = 1;
        #3 PRESET = 1;
        #1;
        chk("rs_kill", {PSEL, PENABLE, gnt0, gnt1, done0, done1}, 32'd0);
        #1 PRESET = 0;
        PREADY = 1;
        tick();
        chk("rs_regrant", {gnt0, gnt1, done0, done1}, 32'b1000);
        tick();
        tick();
        chk("rs_done", {done0, done1}, 32'b10);
        req0 = 0; req1 = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
